// File: rtl/pll_preset_sequencer.sv
// pll_preset_sequencer
//   Selects one of N_PRESETS clock presets and applies it to a PLL
//   reconfiguration port. The preset selector is synchronised and debounced.
//   A change starts a write sequence: mode, fractional-M, optional M-counter,
//   then start. After that the block follows the PLL through unlock and relock.
//   It holds sys_reset high until the new clock has been locked for RESET_HOLD
//   cycles.
//
//   Handshake: a register write is a one-cycle mgmt_write strobe. It is issued
//   only in a cycle where mgmt_waitrequest is low. The next write cannot start
//   until the strobe has dropped for at least one cycle.
//
// Ports
//   clk              management clock
//   reset            asynchronous, active-high reset
//   sel              requested preset index (asynchronous)
//   frac_table       fractional-M word per preset, preset i at [32*i +: 32]
//   mcnt_table       M-counter word per preset (used only when WRITE_M=1)
//   mgmt_waitrequest reconfiguration port busy
//   pll_locked       PLL lock indicator (asynchronous)
//   mgmt_write       single-cycle write strobe
//   mgmt_address     register address
//   mgmt_writedata   register data
//   busy             a sequence is in progress
//   done             one-cycle pulse when a sequence completes
//   timeout          sticky lock-timeout flag of the last sequence
//   cur_sel          preset last applied
//   sys_reset        reset request for the downstream clocked core
//   dbg_state        current FSM state, for checkers
module pll_preset_sequencer #(
    parameter int N_PRESETS     = 4,
    parameter int SELW          = 2,
    parameter int WRITE_M       = 0,
    parameter int STABLE_CYCLES = 4,
    parameter int UNLOCK_WAIT   = 256,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int RESET_HOLD    = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SELW-1:0]        sel,
    input  logic [32*N_PRESETS-1:0] frac_table,
    input  logic [32*N_PRESETS-1:0] mcnt_table,
    input  logic                   mgmt_waitrequest,
    input  logic                   pll_locked,
    output logic                   mgmt_write,
    output logic [5:0]             mgmt_address,
    output logic [31:0]            mgmt_writedata,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [SELW-1:0]        cur_sel,
    output logic                   sys_reset,
    output logic [3:0]             dbg_state
);

    localparam logic [3:0] S_INIT        = 4'd0;
    localparam logic [3:0] S_IDLE        = 4'd1;
    localparam logic [3:0] S_MODE        = 4'd2;
    localparam logic [3:0] S_FRAC        = 4'd3;
    localparam logic [3:0] S_MCNT        = 4'd4;
    localparam logic [3:0] S_START       = 4'd5;
    localparam logic [3:0] S_WAIT_UNLOCK = 4'd6;
    localparam logic [3:0] S_WAIT_LOCK   = 4'd7;
    localparam logic [3:0] S_HOLD        = 4'd8;

    // One shared cycle counter, sized for the longest wait.
    localparam int MAX_A   = (UNLOCK_WAIT > LOCK_TIMEOUT) ? UNLOCK_WAIT : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > RESET_HOLD) ? MAX_A : RESET_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] UW_LAST = CW'(UNLOCK_WAIT - 1);
    localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] RH_LAST = CW'(RESET_HOLD - 1);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SCW-1:0] STABLE_C = SCW'(STABLE_CYCLES);

    // ------------------------------------------------------------------
    // Input synchronisers and selector debounce filter
    // ------------------------------------------------------------------
    logic [SELW-1:0] sel_s1_q, sel_s2_q, cand_q, sel_f_q;
    logic [SCW-1:0]  stab_cnt_q;
    logic            settled_q;
    logic            lock_s1_q, lock_s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_s1_q   <= '0;
            sel_s2_q   <= '0;
            cand_q     <= '0;
            stab_cnt_q <= '0;
            sel_f_q    <= '0;
            settled_q  <= 1'b0;
            lock_s1_q  <= 1'b0;
            lock_s2_q  <= 1'b0;
        end else begin
            sel_s1_q  <= sel;
            sel_s2_q  <= sel_s1_q;
            lock_s1_q <= pll_locked;
            lock_s2_q <= lock_s1_q;
            // stab_cnt_q counts consecutive synchronised samples equal to cand_q.
            if (sel_s2_q != cand_q) begin
                cand_q     <= sel_s2_q;
                stab_cnt_q <= SCW'(1);
            end else if (stab_cnt_q != STABLE_C) begin
                stab_cnt_q <= stab_cnt_q + SCW'(1);
            end
            if (stab_cnt_q == STABLE_C) begin
                sel_f_q   <= cand_q;
                settled_q <= 1'b1;
            end
        end
    end

    logic sel_ok;
    assign sel_ok = settled_q && (int'(sel_f_q) < N_PRESETS);

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [3:0]      state_q, state_d;
    logic [SELW-1:0] target_q, target_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            wr_q, wr_d;
    logic [5:0]      addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic [SELW-1:0] cur_sel_q, cur_sel_d;
    logic            sys_reset_q, sys_reset_d;

    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_next;

    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    // Register address, data and successor for whichever write state is active.
    always_comb begin
        wr_addr = 6'd0;
        wr_data = 32'd0;
        wr_next = S_IDLE;
        case (state_q)
            S_MODE: begin
                wr_addr = 6'd0;
                wr_next = S_FRAC;
            end
            S_FRAC: begin
                wr_addr = 6'd7;
                wr_data = frac_table[{target_q, 5'b0} +: 32];
                wr_next = (WRITE_M != 0) ? S_MCNT : S_START;
            end
            S_MCNT: begin
                wr_addr = 6'd4;
                wr_data = mcnt_table[{target_q, 5'b0} +: 32];
                wr_next = S_START;
            end
            S_START: begin
                wr_addr = 6'd2;
                wr_next = S_WAIT_UNLOCK;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cnt_d       = cnt_q;
        wr_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        cur_sel_d   = cur_sel_q;
        sys_reset_d = sys_reset_q;
        case (state_q)
            // After reset one sequence always runs, even if sel matches cur_sel.
            S_INIT, S_IDLE: begin
                if (sel_ok && (state_q == S_INIT || sel_f_q != cur_sel_q)) begin
                    target_d    = sel_f_q;
                    timeout_d   = 1'b0;
                    sys_reset_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_MODE;
                end
            end
            S_MODE, S_FRAC, S_MCNT, S_START: begin
                if (wr_q) begin
                    // Strobe was high last cycle: drop it and move on.
                    state_d = wr_next;
                    cnt_d   = '0;
                end else if (!mgmt_waitrequest) begin
                    wr_d   = 1'b1;
                    addr_d = wr_addr;
                    data_d = wr_data;
                end
            end
            S_WAIT_UNLOCK: begin
                if (!lock_s2_q || cnt_q >= UW_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s2_q) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q >= LT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HOLD;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HOLD: begin
                // After a lock timeout the lock state is ignored, so HOLD
                // always ends after RESET_HOLD cycles.
                if (!timeout_q && !lock_s2_q) begin
                    cnt_d = '0;
                end else if (cnt_q >= RH_LAST) begin
                    cur_sel_d   = target_q;
                    sys_reset_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_INIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_INIT;
            target_q    <= '0;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= 6'd0;
            data_q      <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cur_sel_q   <= '0;
            sys_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cur_sel_q   <= cur_sel_d;
            sys_reset_q <= sys_reset_d;
        end
    end

    assign mgmt_write     = wr_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign cur_sel        = cur_sel_q;
    assign sys_reset      = sys_reset_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pll_preset_sequencer.sv
// tb_pll_preset_sequencer
//   Directed bench for pll_preset_sequencer. Two instances share all inputs:
//   dut (WRITE_M=0) and dut_m (WRITE_M=1). The waits are shortened so that
//   every scenario completes in a few hundred cycles.
module tb_pll_preset_sequencer;

    localparam int N_PRESETS = 5;
    localparam int SELW      = 3;
    localparam logic [3:0] ST_INIT = 4'd0;
    localparam logic [3:0] ST_FRAC = 4'd3;

    logic clk, reset;
    logic [SELW-1:0] sel;
    logic [32*N_PRESETS-1:0] frac_table, mcnt_table;
    logic waitreq, locked;

    logic mgmt_write, busy, done, timeout, sys_reset;
    logic [5:0] mgmt_address;
    logic [31:0] mgmt_writedata;
    logic [SELW-1:0] cur_sel;
    logic [3:0] dbg_state;

    logic m_write, m_busy, m_done, m_timeout, m_sys_reset;
    logic [5:0] m_address;
    logic [31:0] m_writedata;
    logic [SELW-1:0] m_cur_sel;
    logic [3:0] m_dbg_state;

    pll_preset_sequencer #(
        .N_PRESETS(N_PRESETS), .SELW(SELW), .WRITE_M(0), .STABLE_CYCLES(4),
        .UNLOCK_WAIT(16), .LOCK_TIMEOUT(60), .RESET_HOLD(20)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .frac_table(frac_table),
        .mcnt_table(mcnt_table), .mgmt_waitrequest(waitreq), .pll_locked(locked),
        .mgmt_write(mgmt_write), .mgmt_address(mgmt_address),
        .mgmt_writedata(mgmt_writedata), .busy(busy), .done(done),
        .timeout(timeout), .cur_sel(cur_sel), .sys_reset(sys_reset),
        .dbg_state(dbg_state)
    );

    pll_preset_sequencer #(
        .N_PRESETS(N_PRESETS), .SELW(SELW), .WRITE_M(1), .STABLE_CYCLES(4),
        .UNLOCK_WAIT(16), .LOCK_TIMEOUT(60), .RESET_HOLD(20)
    ) dut_m (
        .clk(clk), .reset(reset), .sel(sel), .frac_table(frac_table),
        .mcnt_table(mcnt_table), .mgmt_waitrequest(waitreq), .pll_locked(locked),
        .mgmt_write(m_write), .mgmt_address(m_address),
        .mgmt_writedata(m_writedata), .busy(m_busy), .done(m_done),
        .timeout(m_timeout), .cur_sel(m_cur_sel), .sys_reset(m_sys_reset),
        .dbg_state(m_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [37:0] exp_q[$];
    logic [37:0] exp_m_q[$];
    logic [37:0] got_q[$];
    logic [37:0] got_m_q[$];
    int idx_a = 0;
    int idx_m = 0;
    int done_cnt = 0;
    int done_m_cnt = 0;
    int viol = 0;
    logic wait_at_edge = 1'b0;
    logic prev_wr = 1'b0;
    logic prev_wr_m = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Write monitor: logs every strobe and flags strobes issued against a
    // high waitrequest or back-to-back strobes.
    always @(posedge clk) wait_at_edge <= waitreq;

    always @(negedge clk) begin
        if (mgmt_write) begin
            got_q.push_back({mgmt_address, mgmt_writedata});
            if (wait_at_edge || prev_wr) viol++;
        end
        if (m_write) begin
            got_m_q.push_back({m_address, m_writedata});
            if (wait_at_edge || prev_wr_m) viol++;
        end
        prev_wr   = mgmt_write;
        prev_wr_m = m_write;
        if (done) done_cnt++;
        if (m_done) done_m_cnt++;
    end

    // ---------------- driver helpers ----------------
    function automatic bit hit(input int what);
        case (what)
            0:       hit = mgmt_write && (mgmt_address == 6'd0);
            1:       hit = mgmt_write && (mgmt_address == 6'd2);
            default: hit = busy;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int what, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = hit(what);
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    // Wait for both instances to finish n sequences and settle in IDLE.
    task automatic wait_idle(input string tag, input int base, input int base_m,
                             input int n, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = (done_cnt - base >= n) && (done_m_cnt - base_m >= n) && !busy && !m_busy;
        end
        check(tag, 64'(ok), 64'd1);
        check({tag, "_pulses"}, 64'(done_cnt - base), 64'(n));
        check({tag, "_pulses_m"}, 64'(done_m_cnt - base_m), 64'(n));
    endtask

    task automatic push_seq(input logic [31:0] f, input logic [31:0] m);
        exp_q.push_back({6'd0, 32'd0});
        exp_q.push_back({6'd7, f});
        exp_q.push_back({6'd2, 32'd0});
        exp_m_q.push_back({6'd0, 32'd0});
        exp_m_q.push_back({6'd7, f});
        exp_m_q.push_back({6'd4, m});
        exp_m_q.push_back({6'd2, 32'd0});
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        check({tag, "_wr_count_m"}, 64'(got_m_q.size()), 64'(exp_m_q.size()));
        for (int i = idx_a; i < exp_q.size(); i++)
            if (i < got_q.size()) check({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
        for (int i = idx_m; i < exp_m_q.size(); i++)
            if (i < got_m_q.size()) check({tag, "_wr_m"}, 64'(got_m_q[i]), 64'(exp_m_q[i]));
        idx_a = exp_q.size();
        idx_m = exp_m_q.size();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_write"}, 64'(mgmt_write), 64'd0);
        check({tag, "_addr"}, 64'(mgmt_address), 64'd0);
        check({tag, "_data"}, 64'(mgmt_writedata), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_cur_sel"}, 64'(cur_sel), 64'd0);
        check({tag, "_sys_reset"}, 64'(sys_reset), 64'd1);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_INIT));
        check({tag, "_m_write"}, 64'(m_write), 64'd0);
        check({tag, "_m_sys_reset"}, 64'(m_sys_reset), 64'd1);
        check({tag, "_m_state"}, 64'(m_dbg_state), 64'(ST_INIT));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b, bm, stall_wr, busy_seen;
        bit ok;
        frac_table = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1000_0000};
        mcnt_table = {32'h0000_0A04, 32'h0000_0A03, 32'h0000_0A02, 32'h0000_0A01, 32'h0000_0A00};
        reset   = 1'b1;
        sel     = 3'd1;
        waitreq = 1'b0;
        locked  = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // 1: first sequence after reset, sel=1, lock toggles 1->0->1
        b = done_cnt; bm = done_m_cnt;
        reset = 1'b0;
        push_seq(32'h1111_1111, 32'h0000_0A01);
        wait_for("t1_start_wr", 1, 100);
        locked = 1'b0;
        repeat (10) @(negedge clk);
        locked = 1'b1;
        wait_idle("t1_idle", b, bm, 1, 300);
        check("t1_cur_sel", 64'(cur_sel), 64'd1);
        check("t1_sys_reset", 64'(sys_reset), 64'd0);
        check("t1_m_cur_sel", 64'(m_cur_sel), 64'd1);
        check("t1_m_sys_reset", 64'(m_sys_reset), 64'd0);
        compare_log("t1");

        // 3: short glitch 1->2->1, then out-of-range preset 6
        sel = 3'd2;
        repeat (2) @(negedge clk);
        sel = 3'd1;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || m_busy) busy_seen++;
        end
        check("t3_glitch_busy", 64'(busy_seen), 64'd0);
        sel = 3'd6;
        busy_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (busy || m_busy) busy_seen++;
        end
        check("t3_oor_busy", 64'(busy_seen), 64'd0);
        check("t3_oor_cur_sel", 64'(cur_sel), 64'd1);
        check("t3_oor_sys_reset", 64'(sys_reset), 64'd0);
        compare_log("t3");

        // 2: waitrequest stall of 20 cycles in FRAC, sel=3
        b = done_cnt; bm = done_m_cnt;
        sel = 3'd3;
        push_seq(32'h3333_3333, 32'h0000_0A03);
        wait_for("t2_mode_wr", 0, 100);
        check("t2_sys_reset_busy", 64'(sys_reset), 64'd1);
        waitreq = 1'b1;
        stall_wr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mgmt_write || m_write) stall_wr++;
        end
        check("t2_stall_writes", 64'(stall_wr), 64'd0);
        check("t2_stall_state", 64'(dbg_state), 64'(ST_FRAC));
        waitreq = 1'b0;
        @(negedge clk);
        check("t2_frac_wr", 64'({mgmt_write, mgmt_address, mgmt_writedata}),
              64'({1'b1, 6'd7, 32'h3333_3333}));
        check("t2_frac_wr_m", 64'({m_write, m_address, m_writedata}),
              64'({1'b1, 6'd7, 32'h3333_3333}));
        wait_for("t2_start_wr", 1, 100);
        locked = 1'b0;
        repeat (10) @(negedge clk);
        locked = 1'b1;
        wait_idle("t2_idle", b, bm, 1, 300);
        check("t2_cur_sel", 64'(cur_sel), 64'd3);
        compare_log("t2");

        // 4: lock never returns -> timeout after LOCK_TIMEOUT, sequence still ends
        b = done_cnt; bm = done_m_cnt;
        locked = 1'b0;
        sel = 3'd2;
        push_seq(32'h2222_2222, 32'h0000_0A02);
        wait_for("t4_start_wr", 1, 100);
        repeat (20) @(negedge clk);
        check("t4_timeout_early", 64'(timeout), 64'd0);
        wait_idle("t4_idle", b, bm, 1, 400);
        check("t4_timeout", 64'(timeout), 64'd1);
        check("t4_m_timeout", 64'(m_timeout), 64'd1);
        check("t4_cur_sel", 64'(cur_sel), 64'd2);
        check("t4_sys_reset", 64'(sys_reset), 64'd0);
        compare_log("t4");

        // 5: sel 1 then 3 during WAIT_LOCK; timeout clears on start
        b = done_cnt; bm = done_m_cnt;
        sel = 3'd1;
        push_seq(32'h1111_1111, 32'h0000_0A01);
        push_seq(32'h3333_3333, 32'h0000_0A03);
        wait_for("t5_busy", 2, 50);
        check("t5_timeout_cleared", 64'(timeout), 64'd0);
        check("t5_sys_reset", 64'(sys_reset), 64'd1);
        wait_for("t5_start_wr", 1, 100);
        repeat (5) @(negedge clk);
        sel = 3'd3;
        repeat (15) @(negedge clk);
        locked = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = done;
        end
        check("t5_first_done", 64'(ok), 64'd1);
        check("t5_first_cur_sel", 64'(cur_sel), 64'd1);
        wait_for("t5_second_busy", 2, 3);
        wait_idle("t5_idle", b, bm, 2, 300);
        check("t5_cur_sel", 64'(cur_sel), 64'd3);
        check("t5_m_cur_sel", 64'(m_cur_sel), 64'd3);
        check("t5_timeout", 64'(timeout), 64'd0);
        compare_log("t5");

        // 6: reset in FRAC, then a fresh full sequence for sel=4
        sel = 3'd4;
        exp_q.push_back({6'd0, 32'd0});
        exp_m_q.push_back({6'd0, 32'd0});
        wait_for("t6_mode_wr", 0, 100);
        @(negedge clk);
        check("t6_in_frac", 64'(dbg_state), 64'(ST_FRAC));
        reset = 1'b1;
        #1;
        check_reset_vals("t6_rst");
        repeat (3) @(negedge clk);
        b = done_cnt; bm = done_m_cnt;
        reset = 1'b0;
        push_seq(32'h4444_4444, 32'h0000_0A04);
        wait_idle("t6_idle", b, bm, 1, 300);
        check("t6_cur_sel", 64'(cur_sel), 64'd4);
        check("t6_m_cur_sel", 64'(m_cur_sel), 64'd4);
        check("t6_sys_reset", 64'(sys_reset), 64'd0);
        compare_log("t6");

        check("write_protocol", 64'(viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
